// File: rtl/vtage_pkg.sv
// Shared types for the VTAGE update scheduler: write-port opcodes, queued
// feedback entry layout and scheduler FSM states.
package vtage_pkg;

  typedef enum logic [1:0] {
    OP_NOP    = 2'd0,
    OP_UPDATE = 2'd1,
    OP_AGE    = 2'd2
  } wr_op_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] result;
    logic        mispredict;
  } fb_entry_t;

  typedef enum logic {
    S_UPD = 1'b0,
    S_AGE = 1'b1
  } sched_state_e;

endpackage

// File: rtl/vtage_fb_fifo.sv
// Multi-write / single-read feedback FIFO. Valid lanes are written in
// ascending lane order into consecutive slots so the queue never has holes.
// Reports occupancy and whether a full set of lanes still fits.
module vtage_fb_fifo
  import vtage_pkg::*;
#(
  parameter  int P_NUM_PRED   = 2,
  parameter  int P_FIFO_DEPTH = 8,
  localparam int PTR_W        = $clog2(P_FIFO_DEPTH),
  localparam int CNT_W        = PTR_W + 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic      [P_NUM_PRED-1:0]       push_valid,
  input  fb_entry_t [P_NUM_PRED-1:0]       push_data,
  input  logic                             pop,
  input  logic                             flush,
  output fb_entry_t                        head,
  output logic      [CNT_W-1:0]            count,
  output logic                             room
);

  fb_entry_t        mem [P_FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_slot [P_NUM_PRED];
  logic [CNT_W-1:0] push_num;

  // Compaction: each valid lane lands after all lower valid lanes.
  always_comb begin
    push_num = '0;
    for (int i = 0; i < P_NUM_PRED; i++) begin
      wr_slot[i] = wr_ptr + push_num[PTR_W-1:0];
      if (push_valid[i]) push_num = push_num + CNT_W'(1);
    end
  end

  assign head = mem[rd_ptr];
  assign room = (CNT_W'(P_FIFO_DEPTH) - count) >= CNT_W'(P_NUM_PRED);

  // Entry storage; payload carries no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < P_NUM_PRED; i++) begin
      if (push_valid[i]) mem[wr_slot[i]] <= push_data[i];
    end
  end

  // Pointers and occupancy; flush discards everything queued.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + push_num[PTR_W-1:0];
      rd_ptr <= rd_ptr + PTR_W'(pop);
      count  <= count + push_num - CNT_W'(pop);
    end
  end

endmodule

// File: rtl/vtage_update_sched.sv
// VTAGE update scheduler: queues per-lane validation feedback and serialises
// it onto the single bank write port, interleaving a periodic usefulness
// aging sweep over every bank entry. Aging takes priority over queued updates.
module vtage_update_sched
  import vtage_pkg::*;
#(
  parameter  int P_NUM_PRED    = 2,
  parameter  int P_NUM_ENTRIES = 1024,
  parameter  int P_FIFO_DEPTH  = 8,
  parameter  int P_AGE_PERIOD  = 4096,
  localparam int IDX_W         = $clog2(P_NUM_ENTRIES)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [P_NUM_PRED*32-1:0]   fb_pc_i,
  input  logic [P_NUM_PRED*32-1:0]   fb_result_i,
  input  logic [P_NUM_PRED-1:0]      fb_valid_i,
  input  logic [P_NUM_PRED-1:0]      fb_mispredict_i,
  output logic                       fb_ready_o,
  input  logic                       flush_i,
  output logic                       wr_valid_o,
  input  logic                       wr_ready_i,
  output logic [1:0]                 wr_op_o,
  output logic [IDX_W-1:0]           wr_idx_o,
  output logic [31:0]                wr_pc_o,
  output logic [31:0]                wr_result_o,
  output logic                       wr_mispredict_o,
  output logic                       age_busy_o,
  output logic [15:0]                drop_cnt_o
);

  localparam int CNT_W = $clog2(P_FIFO_DEPTH) + 1;
  localparam int AGE_W = (P_AGE_PERIOD > 1) ? $clog2(P_AGE_PERIOD) : 1;

  fb_entry_t [P_NUM_PRED-1:0] lane_data;
  logic      [P_NUM_PRED-1:0] push_valid;
  fb_entry_t                  head;
  logic      [CNT_W-1:0]      fifo_count;
  logic                       fifo_room;
  logic                       fifo_empty;

  sched_state_e               state;
  logic                       age_pend;
  logic      [AGE_W-1:0]      age_cnt;

  logic hs, slot_free, upd_hs, age_trig, idx_last, leave_age;
  logic start_age, step_age, take_upd, go_idle;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  function automatic logic [15:0] lane_pop(input logic [P_NUM_PRED-1:0] v);
    logic [15:0] n;
    n = '0;
    for (int i = 0; i < P_NUM_PRED; i++) n = n + {15'd0, v[i]};
    return n;
  endfunction

  // Unpack flat feedback lanes into queue entries.
  always_comb begin
    for (int i = 0; i < P_NUM_PRED; i++) begin
      lane_data[i].pc         = fb_pc_i[i*32 +: 32];
      lane_data[i].result     = fb_result_i[i*32 +: 32];
      lane_data[i].mispredict = fb_mispredict_i[i];
    end
  end

  assign fb_ready_o = fifo_room && !rst_i;
  assign fifo_empty = (fifo_count == '0);
  // A flushing cycle discards its own enqueue without counting it as a drop.
  assign push_valid = (fb_ready_o && !flush_i) ? fb_valid_i : '0;

  vtage_fb_fifo #(
    .P_NUM_PRED  (P_NUM_PRED),
    .P_FIFO_DEPTH(P_FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .push_valid(push_valid),
    .push_data (lane_data),
    .pop       (take_upd),
    .flush     (flush_i),
    .head      (head),
    .count     (fifo_count),
    .room      (fifo_room)
  );

  assign hs        = wr_valid_o && wr_ready_i;
  assign slot_free = !wr_valid_o || wr_ready_i;
  assign upd_hs    = hs && (wr_op_o == OP_UPDATE) && (state == S_UPD);
  assign age_trig  = upd_hs && (age_cnt == AGE_W'(P_AGE_PERIOD - 1));
  assign idx_last  = (wr_idx_o == IDX_W'(P_NUM_ENTRIES - 1));
  assign leave_age = (state == S_AGE) && hs && idx_last;

  // Next-request selection; the trigger handshake starts aging without a gap.
  always_comb begin
    start_age = 1'b0;
    step_age  = 1'b0;
    take_upd  = 1'b0;
    go_idle   = 1'b0;
    if (state == S_AGE) begin
      if (hs) begin
        if (!idx_last)        step_age = 1'b1;
        else if (!fifo_empty) take_upd = 1'b1;
        else                  go_idle  = 1'b1;
      end
    end else if (slot_free) begin
      if (age_pend || age_trig) start_age = 1'b1;
      else if (!fifo_empty)     take_upd  = 1'b1;
      else                      go_idle   = 1'b1;
    end
  end

  // Age period counter and pending flag; counter only moves in S_UPD.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      age_cnt  <= '0;
      age_pend <= 1'b0;
    end else begin
      if (upd_hs) age_cnt <= age_trig ? '0 : age_cnt + AGE_W'(1);
      if (age_trig)       age_pend <= 1'b1;
      else if (leave_age) age_pend <= 1'b0;
    end
  end

  // Saturating count of lanes offered while the queue could not take them.
  always_ff @(posedge clk_i) begin
    if (rst_i)            drop_cnt_o <= '0;
    else if (!fb_ready_o) drop_cnt_o <= sat_add16(drop_cnt_o, lane_pop(fb_valid_i));
  end

  // Scheduler FSM and registered write-port request.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state           <= S_UPD;
      age_busy_o      <= 1'b0;
      wr_valid_o      <= 1'b0;
      wr_op_o         <= OP_NOP;
      wr_idx_o        <= '0;
      wr_pc_o         <= '0;
      wr_result_o     <= '0;
      wr_mispredict_o <= 1'b0;
    end else if (start_age) begin
      state           <= S_AGE;
      age_busy_o      <= 1'b1;
      wr_valid_o      <= 1'b1;
      wr_op_o         <= OP_AGE;
      wr_idx_o        <= '0;
      wr_pc_o         <= '0;
      wr_result_o     <= '0;
      wr_mispredict_o <= 1'b0;
    end else if (step_age) begin
      wr_idx_o        <= wr_idx_o + IDX_W'(1);
    end else if (take_upd) begin
      state           <= S_UPD;
      age_busy_o      <= 1'b0;
      wr_valid_o      <= 1'b1;
      wr_op_o         <= OP_UPDATE;
      wr_idx_o        <= head.pc[IDX_W+1:2];
      wr_pc_o         <= head.pc;
      wr_result_o     <= head.result;
      wr_mispredict_o <= head.mispredict;
    end else if (go_idle) begin
      state           <= S_UPD;
      age_busy_o      <= 1'b0;
      wr_valid_o      <= 1'b0;
      wr_op_o         <= OP_NOP;
      wr_idx_o        <= '0;
      wr_pc_o         <= '0;
      wr_result_o     <= '0;
      wr_mispredict_o <= 1'b0;
    end
  end

endmodule
